// File: rtl/seq_mux_n.sv
// seq_mux_n: registered N-channel mux with a manual select mode and a timed auto-scan mode.
// Define SEQ_MUX_PARITY_EN to add the registered parity output y_par.
module seq_mux_n #(
  parameter  int WIDTH    = 1,
  parameter  int CHANNELS = 4,
  parameter  int SCAN_DIV = 4,
  localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SW-1:0]             sel,
  input  logic                      en,
  input  logic                      mode,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SW-1:0]             ch_out,
  output logic                      wrap,
`ifdef SEQ_MUX_PARITY_EN
  output logic                      y_par,
`endif
  output logic                      sel_err
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DW_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] CH_LAST = SW'(CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [SW-1:0]    ch_out_q, ch_out_d;
  logic             wrap_q, wrap_d;
  logic             sel_err_q, sel_err_d;
  logic [SW-1:0]    ch_q, ch_d;
  logic [DW-1:0]    dw_q, dw_d;
  logic             y_par_q, y_par_d;

  // NOTE: every signal gets a default first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d   = IDLE;
    y_d       = y_q;
    ch_out_d  = ch_out_q;
    y_valid_d = 1'b0;
    wrap_d    = 1'b0;
    sel_err_d = 1'b0;
    ch_d      = ch_q;
    dw_d      = dw_q;

    // en and mode pick the state every cycle; the work done follows the state being entered.
    if (en) state_d = mode ? SCAN : MAN;

    case (state_d)
      MAN: begin
        if (int'(sel) < CHANNELS) begin
          y_d       = din[int'(sel)*WIDTH +: WIDTH];
          ch_out_d  = sel;
          y_valid_d = 1'b1;
        end else begin
          y_d       = '0;
          sel_err_d = 1'b1;
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          // Fresh entry restarts the sweep at channel 0 without capturing.
          ch_d = '0;
          dw_d = '0;
        end else if (dw_q == DW_LAST) begin
          y_d       = din[int'(ch_q)*WIDTH +: WIDTH];
          ch_out_d  = ch_q;
          y_valid_d = 1'b1;
          dw_d      = '0;
          wrap_d    = (ch_q == CH_LAST);
          ch_d      = (ch_q == CH_LAST) ? '0 : ch_q + SW'(1);
        end else begin
          dw_d = dw_q + DW'(1);
        end
      end
      default: ;
    endcase

    // y only changes on a load, so the parity of y_d tracks the loaded value.
    y_par_d = ^y_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ch_out_q  <= '0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
      ch_q      <= '0;
      dw_q      <= '0;
      y_par_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ch_out_q  <= ch_out_d;
      wrap_q    <= wrap_d;
      sel_err_q <= sel_err_d;
      ch_q      <= ch_d;
      dw_q      <= dw_d;
      y_par_q   <= y_par_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ch_out  = ch_out_q;
  assign wrap    = wrap_q;
  assign sel_err = sel_err_q;

`ifdef SEQ_MUX_PARITY_EN
  assign y_par = y_par_q;
`else
  logic unused_par;
  assign unused_par = y_par_q;
`endif

endmodule

// File: tb/tb_seq_mux_n.sv
// Self-checking bench for seq_mux_n: table-driven manual vectors plus scan, abort, reset and
// out-of-range sequences on three instances (4ch/div3, 3ch/div3, 4ch/div1).
`timescale 1ns/1ps
module tb_seq_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main instance: WIDTH=4, CHANNELS=4, SCAN_DIV=3
  logic [15:0] din;
  logic [1:0]  sel;
  logic        en, mode;
  logic [3:0]  y;
  logic        y_valid, wrap, sel_err;
  logic [1:0]  ch_out;

  // Three-channel instance
  logic [11:0] din3;
  logic [1:0]  sel3;
  logic        en3, mode3;
  logic [3:0]  y3;
  logic        y_valid3, wrap3, sel_err3;
  logic [1:0]  ch_out3;

  // SCAN_DIV=1 instance
  logic [15:0] din1;
  logic [1:0]  sel1;
  logic        en1, mode1;
  logic [3:0]  y1;
  logic        y_valid1, wrap1, sel_err1;
  logic [1:0]  ch_out1;

`ifdef SEQ_MUX_PARITY_EN
  logic y_par, y_par3, y_par1;
`endif

  seq_mux_n #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .en(en), .mode(mode),
    .y(y), .y_valid(y_valid), .ch_out(ch_out), .wrap(wrap),
`ifdef SEQ_MUX_PARITY_EN
    .y_par(y_par),
`endif
    .sel_err(sel_err));

  seq_mux_n #(.WIDTH(4), .CHANNELS(3), .SCAN_DIV(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .sel(sel3), .en(en3), .mode(mode3),
    .y(y3), .y_valid(y_valid3), .ch_out(ch_out3), .wrap(wrap3),
`ifdef SEQ_MUX_PARITY_EN
    .y_par(y_par3),
`endif
    .sel_err(sel_err3));

  seq_mux_n #(.WIDTH(4), .CHANNELS(4), .SCAN_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1), .en(en1), .mode(mode1),
    .y(y1), .y_valid(y_valid1), .ch_out(ch_out1), .wrap(wrap1),
`ifdef SEQ_MUX_PARITY_EN
    .y_par(y_par1),
`endif
    .sel_err(sel_err1));

  typedef struct {
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] din;
    logic [3:0]  exp_y;
    logic        exp_valid;
    logic [1:0]  exp_ch;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic       valid;
    logic [1:0] ch;
    logic       wrap;
    logic       err;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[8];
  int   cyc, last;
  logic found;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'd0, 16'h4321, 4'h1, 1'b1, 2'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 16'h4321, 4'h2, 1'b1, 2'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 16'h4321, 4'h3, 1'b1, 2'd2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 2'd3, 16'h4321, 4'h4, 1'b1, 2'd3, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd1, 16'h8765, 4'h6, 1'b1, 2'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 2'd3, 16'h8765, 4'h6, 1'b0, 2'd1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 16'hFFFF, 4'h6, 1'b0, 2'd1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 2'd2, 16'hF0A5, 4'h0, 1'b1, 2'd2, 1'b0};

    rst_n = 1'b1;
    din = '0; sel = '0; en = 1'b0; mode = 1'b0;
    din3 = '0; sel3 = '0; en3 = 1'b0; mode3 = 1'b0;
    din1 = '0; sel1 = '0; en1 = 1'b0; mode1 = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_y", y, 0);
    check("rst_valid", y_valid, 0);
    check("rst_ch_out", ch_out, 0);
    check("rst_wrap", wrap, 0);
    check("rst_sel_err", sel_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Manual mode and idle hold, table driven through the scoreboard
    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; sel = vecs[i].sel; din = vecs[i].din;
      sb.push_back('{y: vecs[i].exp_y, valid: vecs[i].exp_valid, ch: vecs[i].exp_ch,
                     wrap: 1'b0, err: vecs[i].exp_err});
      step();
      e = sb.pop_front();
      check($sformatf("man%0d_y", i), y, e.y);
      check($sformatf("man%0d_valid", i), y_valid, e.valid);
      check($sformatf("man%0d_ch", i), ch_out, e.ch);
      check($sformatf("man%0d_err", i), sel_err, e.err);
      check($sformatf("man%0d_wrap", i), wrap, e.wrap);
    end

    // Scan order: captures every 3 cycles, wrap only with channel 3
    sb.delete();
    for (int k = 0; k < 8; k++)
      sb.push_back('{y: 4'(k % 4 + 1), valid: 1'b1, ch: 2'(k % 4), wrap: (k % 4 == 3), err: 1'b0});
    en = 1'b1; mode = 1'b1; din = 16'h4321; sel = 2'd3;
    step();
    check("scan_entry_valid", y_valid, 0);
    check("scan_entry_err", sel_err, 0);
    cyc = 0; last = 0;
    for (int t = 0; t < 60 && sb.size() > 0; t++) begin
      step();
      cyc++;
      if (wrap && !y_valid) check("scan_wrap_without_valid", wrap, 0);
      if (y_valid) begin
        e = sb.pop_front();
        check($sformatf("scan_gap_c%0d", cyc), cyc - last, 3);
        check($sformatf("scan_y_c%0d", cyc), y, e.y);
        check($sformatf("scan_ch_c%0d", cyc), ch_out, e.ch);
        check($sformatf("scan_wrap_c%0d", cyc), wrap, e.wrap);
        last = cyc;
      end
    end
    check("scan_pending_captures", sb.size(), 0);

    // Abort two cycles after the channel-1 capture, then re-enter
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      step();
      if (y_valid && ch_out == 2'd1) found = 1'b1;
    end
    check("abort_find_ch1", found, 1);
    step();
    check("abort_e1_valid", y_valid, 0);
    mode = 1'b0; sel = 2'd0;
    step();
    check("abort_man_ch", ch_out, 0);
    check("abort_man_y", y, 1);
    mode = 1'b1;
    step();
    check("abort_reentry_valid", y_valid, 0);
    step();
    check("abort_re1_valid", y_valid, 0);
    step();
    check("abort_re2_valid", y_valid, 0);
    step();
    check("abort_re3_valid", y_valid, 1);
    check("abort_re3_ch", ch_out, 0);
    check("abort_re3_y", y, 1);

    // Asynchronous reset mid-scan with y=A, then restart from channel 0
    din = 16'h43A1;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      step();
      if (y_valid && ch_out == 2'd1) found = 1'b1;
    end
    check("rst_mid_find_ch1", found, 1);
    check("rst_mid_pre_y", y, 4'hA);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_y", y, 0);
    check("rst_mid_valid", y_valid, 0);
    check("rst_mid_ch_out", ch_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_rel_entry_valid", y_valid, 0);
    step();
    step();
    check("rst_rel_c2_valid", y_valid, 0);
    step();
    check("rst_rel_c3_valid", y_valid, 1);
    check("rst_rel_c3_ch", ch_out, 0);
    check("rst_rel_c3_y", y, 1);

    // Out-of-range select on the three-channel instance
    en3 = 1'b1; mode3 = 1'b0; din3 = 12'h321; sel3 = 2'd2;
    step();
    check("oor_sel2_y", y3, 3);
    check("oor_sel2_ch", ch_out3, 2);
    sel3 = 2'd3;
    step();
    check("oor_sel3_y", y3, 0);
    check("oor_sel3_err", sel_err3, 1);
    check("oor_sel3_valid", y_valid3, 0);
    check("oor_sel3_ch_hold", ch_out3, 2);
    sel3 = 2'd1;
    step();
    check("oor_sel1_y", y3, 2);
    check("oor_sel1_err", sel_err3, 0);
    check("oor_sel1_valid", y_valid3, 1);

    // Three-channel scan wraps after channel 2; sel=3 is ignored
    sel3 = 2'd3; mode3 = 1'b1;
    step();
    check("s3_entry_valid", y_valid3, 0);
    for (int t = 1; t <= 12; t++) begin
      step();
      check($sformatf("s3_err_t%0d", t), sel_err3, 0);
      if (t % 3 == 0) begin
        check($sformatf("s3_valid_t%0d", t), y_valid3, 1);
        check($sformatf("s3_y_t%0d", t), y3, (t / 3 - 1) % 3 + 1);
        check($sformatf("s3_ch_t%0d", t), ch_out3, (t / 3 - 1) % 3);
        check($sformatf("s3_wrap_t%0d", t), wrap3, ((t / 3 - 1) % 3 == 2) ? 1 : 0);
      end else begin
        check($sformatf("s3_valid_t%0d", t), y_valid3, 0);
      end
    end
    en3 = 1'b0;

    // SCAN_DIV=1 captures every cycle after entry
    en1 = 1'b1; mode1 = 1'b1; din1 = 16'h4321;
    step();
    check("d1_entry_valid", y_valid1, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("d1_valid_%0d", k), y_valid1, 1);
      check($sformatf("d1_y_%0d", k), y1, k % 4 + 1);
      check($sformatf("d1_ch_%0d", k), ch_out1, k % 4);
      check($sformatf("d1_wrap_%0d", k), wrap1, (k % 4 == 3) ? 1 : 0);
    end
    en1 = 1'b0;

`ifdef SEQ_MUX_PARITY_EN
    en = 1'b1; mode = 1'b0; sel = 2'd2; din = 16'h0700;
    step();
    check("par_0111", y_par, 1);
    din = 16'h0600;
    step();
    check("par_0110", y_par, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mux_n.md
SEQ_MUX_N -- requirements
Module: seq_mux_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, bit width of each data channel (1..32).
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (2..16, power of two not required).
REQ-003 The block SHALL have parameter SCAN_DIV, default 4, dwell cycles per channel in scan mode (1..255).
REQ-004 SW = ceil(log2(CHANNELS)) SHALL be the width of all channel-index ports.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port din, input, CHANNELS*WIDTH, packed channel data, with channel k at bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port sel, input, SW, manual channel select.
REQ-009 The block SHALL have port en, input, 1, block enable.
REQ-010 The block SHALL have port mode, input, 1, channel source: 0 = manual (sel), 1 = auto-scan.
REQ-011 The block SHALL have port y, output, WIDTH, registered selected data.
REQ-012 The block SHALL have port y_valid, output, 1, y updated this cycle.
REQ-013 The block SHALL have port ch_out, output, SW, channel index that produced the current y.
REQ-014 The block SHALL have port wrap, output, 1, one-cycle pulse when the scan completes channel CHANNELS-1.
REQ-015 The block SHALL have port sel_err, output, 1, registered flag that sel >= CHANNELS in manual mode.

Function
REQ-016 The block SHALL implement a three-state FSM with states IDLE, MAN and SCAN; en=0 selects IDLE, en=1 with mode=0 selects MAN, and en=1 with mode=1 selects SCAN, with en and mode sampled on every clock edge.
REQ-017 In IDLE, y and ch_out SHALL hold their values, and y_valid, wrap and sel_err SHALL be 0.
REQ-018 In MAN with sel < CHANNELS, each cycle y SHALL load din[sel], ch_out SHALL load sel, y_valid SHALL be 1 and sel_err SHALL be 0, with latency 1 clock from sel/din to y.
REQ-019 In MAN with sel >= CHANNELS, y SHALL load 0, ch_out SHALL hold, y_valid SHALL be 0 and sel_err SHALL be 1.
REQ-020 On every entry into SCAN from another state, the internal channel counter ch and the dwell counter dw SHALL be cleared to 0, with no capture in the entry cycle.
REQ-021 In SCAN, dw SHALL increment every cycle, and when dw == SCAN_DIV-1 the block SHALL load din[ch] into y, load ch into ch_out, pulse y_valid for 1 cycle, clear dw and advance ch.
REQ-022 In SCAN, ch SHALL wrap from CHANNELS-1 to 0, and wrap SHALL pulse in the same cycle as the y_valid for channel CHANNELS-1.
REQ-023 With SCAN_DIV=1, the block SHALL capture one channel on every cycle after the entry cycle.
REQ-024 The first SCAN capture SHALL occur SCAN_DIV cycles after the entry edge.
REQ-025 If mode or en changes mid-scan, the scan SHALL abort immediately without a final capture, and re-entry SHALL restart at channel 0.
REQ-026 In SCAN, sel and sel_err SHALL be ignored, and sel_err SHALL be 0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force y=0, y_valid=0, ch_out=0, wrap=0, sel_err=0, ch=0, dw=0 and state=IDLE.
REQ-028 Reset SHALL be released synchronously, with the FSM evaluating en and mode at the first rising clk after rst_n rises.
REQ-029 Reset asserted mid-scan SHALL discard all progress.

Configuration
REQ-030 With macro SEQ_MUX_PARITY_EN defined, the block SHALL provide an additional output y_par, 1 bit, registered alongside y and equal to XOR of the y value loaded, and 0 at reset.
REQ-031 Without SEQ_MUX_PARITY_EN, port y_par SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=4, CHANNELS=4, SCAN_DIV=3 unless stated)
REQ-032 Reset check: rst_n=0 mid-run with y=4'hA -> y=0, ch_out=0 and y_valid=0 immediately, without waiting for clk.
REQ-033 Manual sweep: en=1, mode=0, din=16'h4321, sel stepped 0..3 each cycle -> y = 1,2,3,4 one cycle after each sel, y_valid=1 throughout.
REQ-034 Out-of-range select (CHANNELS=3, din=12'h321): sel=3 -> next cycle y=0, sel_err=1, y_valid=0; then sel=1 -> y=2, sel_err=0.
REQ-035 Scan order: en=1, mode=1, din=16'h4321 -> y_valid pulses every 3 cycles with y = 1,2,3,4,1..., and wrap=1 only with the y=4 capture.
REQ-036 Scan abort: switch mode to 0 two cycles after the ch=1 capture, then back to 1 -> no capture of ch=2, and the next capture is ch=0 three cycles after re-entry.
REQ-037 Parity build (SEQ_MUX_PARITY_EN): manual sel=2 with channel 2 = 4'b0111 -> y_par=1; with channel 2 = 4'b0110 -> y_par=0.
